// File: rtl/izh_neuron_update_ctrl_pkg.sv
// Shared definitions for the neuron update controller: FSM encoding and
// the layout of the datapath event word.
package izh_neuron_update_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_EVAL = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    // event_out[SPK_BIT] is the spike flag; the bits below it carry burst info.
    localparam int SPK_BIT = 6;

endpackage

// File: rtl/izh_spk_buf.sv
// One-entry valid/ready register slice holding the most recent spike word.
// A full slice can accept a new entry in the same cycle its entry is popped.
module izh_spk_buf
    import izh_neuron_update_ctrl_pkg::*;
#(
    parameter int W = 14
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         can_push
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    assign can_push = ~valid_reg | ready;
    assign valid    = valid_reg;
    assign data     = data_reg;

    // data_reg only changes on an accepted push, which keeps it stable while stalled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (push && can_push) begin
            valid_reg <= 1'b1;
            data_reg  <= push_data;
        end else if (ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/izh_neuron_update_ctrl.sv
// Read-modify-write sequencer for the neuron state SRAM, arbitrating between
// single-neuron synaptic updates and full time-reference sweeps.
module izh_neuron_update_ctrl
    import izh_neuron_update_ctrl_pkg::*;
#(
    parameter int N   = 256,
    parameter int N_W = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           syn_req,
    input  logic [N_W-1:0] syn_neur,
    input  logic [2:0]     syn_weight,
    input  logic           syn_sign,
    output logic           syn_ack,
    input  logic           tref_req,
    output logic           tref_ack,
    input  logic           burst_end_in,
    output logic           sram_cs,
    output logic           sram_we,
    output logic [N_W-1:0] sram_addr,
    output logic           nrn_syn_event,
    output logic           nrn_time_ref,
    output logic [2:0]     nrn_weight,
    output logic           nrn_sign,
    output logic           nrn_burst_end,
    input  logic [6:0]     nrn_event_out,
    output logic           spk_valid,
    output logic [N_W+5:0] spk_data,
    input  logic           spk_ready,
    output logic           busy
);

    localparam logic [N_W-1:0] LAST_NEUR = N_W'(N - 1);

    state_t         state_reg;
    logic           tref_mode_reg;
    logic [N_W-1:0] cnt_reg;
    logic [N_W-1:0] neur_reg;
    logic [2:0]     weight_reg;
    logic           sign_reg;
    logic           burst_end_reg;

    logic           spike;
    logic           can_push;
    logic           spk_push;
    logic           in_eval_or_wr;

    assign spike         = nrn_event_out[SPK_BIT];
    assign spk_push      = (state_reg == ST_EVAL) && spike && can_push;
    assign in_eval_or_wr = (state_reg == ST_EVAL) || (state_reg == ST_WR);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            tref_mode_reg <= 1'b0;
            cnt_reg       <= '0;
            neur_reg      <= '0;
            weight_reg    <= '0;
            sign_reg      <= 1'b0;
            burst_end_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (tref_req) begin
                        tref_mode_reg <= 1'b1;
                        cnt_reg       <= '0;
                        burst_end_reg <= burst_end_in;
                        state_reg     <= ST_RD;
                    end else if (syn_req) begin
                        tref_mode_reg <= 1'b0;
                        neur_reg      <= syn_neur;
                        weight_reg    <= syn_weight;
                        sign_reg      <= syn_sign;
                        burst_end_reg <= burst_end_in;
                        state_reg     <= ST_RD;
                    end
                end
                ST_RD: state_reg <= ST_EVAL;
                ST_EVAL: begin
                    // A spike that cannot be buffered holds the update before write-back.
                    if (!spike || can_push) begin
                        state_reg <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (tref_mode_reg && (cnt_reg != LAST_NEUR)) begin
                        cnt_reg   <= cnt_reg + 1'b1;
                        state_reg <= ST_RD;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy          = (state_reg != ST_IDLE);
    assign sram_cs       = (state_reg == ST_RD) || (state_reg == ST_WR);
    assign sram_we       = (state_reg == ST_WR);
    assign sram_addr     = tref_mode_reg ? cnt_reg : neur_reg;
    assign nrn_syn_event = in_eval_or_wr;
    assign nrn_time_ref  = in_eval_or_wr && tref_mode_reg;
    assign nrn_weight    = weight_reg;
    assign nrn_sign      = sign_reg;
    assign nrn_burst_end = burst_end_reg;
    assign syn_ack       = (state_reg == ST_WR) && !tref_mode_reg;
    assign tref_ack      = (state_reg == ST_WR) && tref_mode_reg && (cnt_reg == LAST_NEUR);

    izh_spk_buf #(
        .W(N_W + 6)
    ) u_spk_buf (
        .CLK      (CLK),
        .RST      (RST),
        .push     (spk_push),
        .push_data({sram_addr, nrn_event_out[SPK_BIT-1:0]}),
        .ready    (spk_ready),
        .valid    (spk_valid),
        .data     (spk_data),
        .can_push (can_push)
    );

endmodule
